pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in i_clk cycles and
// flags a static input when no rising edge arrives within TIMEOUT cycles.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             en,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic             o_valid,
  output logic             o_static,
  output logic             o_level
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STATIC} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);

  state_t           state, state_d;
  logic             s1, s2, s_prev;
  logic             rise, fall;
  logic [CNT_W-1:0] per_cnt, per_d;
  logic [CNT_W-1:0] hi_cnt, hi_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d;

  // Synchronizer keeps running even while en is low so edges are clean on re-enable.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= i_pwm;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  assign rise = s2 & ~s_prev;
  assign fall = ~s2 & s_prev;

  // In IDLE the period counter doubles as the no-edge timer.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    per_d    = per_cnt;
    hi_d     = hi_cnt;
    period_d = o_period_cnt;
    high_d   = o_high_cnt;
    valid_d  = 1'b0;
    if (!en) begin
      state_d  = IDLE;
      per_d    = '0;
      hi_d     = '0;
      period_d = '0;
      high_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            per_d   = ONE;
            hi_d    = ONE;
          end else if (per_cnt >= TO - ONE) begin
            state_d = STATIC;
            per_d   = '0;
          end else begin
            per_d = per_cnt + ONE;
          end
        end
        HIGH: begin
          if (per_cnt >= TO) begin
            state_d = STATIC;
            per_d   = '0;
            hi_d    = '0;
          end else if (fall) begin
            state_d = LOW;
            per_d   = per_cnt + ONE;
          end else begin
            per_d = per_cnt + ONE;
            hi_d  = hi_cnt + ONE;
          end
        end
        LOW: begin
          // A rise landing on the timeout cycle still closes the measurement.
          if (rise) begin
            state_d  = HIGH;
            period_d = per_cnt;
            high_d   = hi_cnt;
            valid_d  = 1'b1;
            per_d    = ONE;
            hi_d     = ONE;
          end else if (per_cnt >= TO) begin
            state_d = STATIC;
            per_d   = '0;
            hi_d    = '0;
          end else begin
            per_d = per_cnt + ONE;
          end
        end
        STATIC: begin
          if (rise) begin
            state_d = HIGH;
            per_d   = ONE;
            hi_d    = ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      o_period_cnt <= '0;
      o_high_cnt   <= '0;
      o_valid      <= 1'b0;
    end else begin
      state        <= state_d;
      per_cnt      <= per_d;
      hi_cnt       <= hi_d;
      o_period_cnt <= period_d;
      o_high_cnt   <= high_d;
      o_valid      <= valid_d;
    end
  end

  assign o_static = (state == STATIC);
  assign o_level  = o_static & s2;

endmodule
